alu_arbiter_2ch: RTL and testbench
==================================

# alu_arbiter_2ch

Two-channel arbiter and sequencer for the shared 4-bit ALU datapath. It accepts operation requests from two independent requesters over valid/ready handshakes and grants one at a time with round-robin fairness. It latches the winner's operands and opcode and evaluates the ALU function. It returns the registered result, tagged with the originating channel, over a valid/ready response port. It sits between the two client blocks and the single ALU instance, so that neither client drives the ALU directly.

## Interface
- No parameters; data width fixed at 4, opcode width fixed at 3.
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0_valid  input  1  channel 0 request present
- req0_ready  output  1  channel 0 request accepted this cycle
- req0_a, req0_b  input  4 each  channel 0 operands
- req0_op  input  3  channel 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as channel 0, for channel 1
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  4  ALU result
- rsp_zero  output  1  rsp_data == 0
- rsp_ch  output  1  channel that issued the request

## Operation
- Opcode map (all results mod 16):
  - 000: A+B
  - 001: A−B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: ~A
  - 110: A+1
  - 111: A−1
- B is ignored for opcodes 101–111.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no reqN_valid is high, stay in IDLE.
  - If exactly one reqN_valid is high, grant that channel.
  - If both are high, grant the channel ≠ last_grant.
  - On grant: reqN_ready=1 for the granted channel only; latch a, b, op and channel id into operand registers; update last_grant; go to EXEC.
- EXEC:
  - ALU evaluates the latched operands.
  - Result, zero flag and channel are captured into the response registers.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_zero and rsp_ch are held stable.
  - When rsp_ready=1: complete the transfer and go to IDLE.
  - Otherwise stay in RESP.
- req0_ready and req1_ready are 0 outside IDLE. Both are never high in the same cycle.
- reqN_ready is combinational from state, both reqN_valid inputs and last_grant. It does not depend on rsp_ready.
- A requester that drops valid before being granted is simply not served. No request is queued inside the block.
- last_grant resets to 1, so channel 0 wins the first contention.
- Exactly one transaction is in flight at a time.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_ch=0, last_grant=1, req0_ready=0, req1_ready=0.
- Latency: handshake accepted at edge N (end of IDLE cycle) → rsp_valid=1 during cycle N+2.
- Throughput: at most one request per 3 cycles when rsp_ready is held high; the next grant can occur in the cycle after the response handshake.
- Backpressure: rsp_valid stays high and rsp_* stay unchanged for every cycle until rsp_ready=1.
- Asserting rst in any state returns all registers to reset values immediately and discards the in-flight transaction; no response is issued for it.
- Arithmetic wrap examples:
  - F+1 = 0 with rsp_zero=1
  - 0−1 = F
  - 3−5 = E

## Test plan
- Single request: ch0 a=3, b=4, op=000 in IDLE → req0_ready=1 that cycle; two cycles later rsp_valid=1, rsp_data=7, rsp_zero=0, rsp_ch=0.
- Contention and fairness: both channels valid continuously (ch0 op=010 a=C b=A; ch1 op=100 a=C b=A), rsp_ready=1 → grants alternate ch0, ch1, ch0…; responses alternate 8 (ch0) and 6 (ch1).
- Backpressure: ch1 a=F op=110, rsp_ready=0 for 5 cycles → rsp_valid held, rsp_data=0, rsp_zero=1, rsp_ch=1 stable; both ready lines 0; completes on the first rsp_ready=1.
- Opcode sweep: ch0 a=5, b=9 for ops 000–111 → responses E, C, 1, D, C, A, 6, 4.
- Reset mid-operation: rst asserted during EXEC → rsp_valid stays 0, state IDLE. A new ch1 request after reset is granted before ch0 under contention? No: last_grant=1, so ch0 wins first contention after reset.
- Valid withdrawal: ch1 raises valid while the FSM is in RESP, then drops it before IDLE → ch1 is never granted and no ch1 response appears.

Source files
------------

// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin arbiter in front of a shared 4-bit ALU.
// One transaction in flight: grant in IDLE, evaluate in EXEC, hold the response in RESP.
module alu_arbiter_2ch (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [2:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_data,
   output logic       rsp_zero,
   output logic       rsp_ch
);

   localparam int unsigned DW = 4;
   localparam int unsigned OW = 3;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [OW-1:0] op;
      logic          ch;
   } opnd_t;

   state_t        state, state_nxt;
   opnd_t         opnd;
   logic          last_grant;
   logic          grant0, grant1;
   logic [DW-1:0] alu_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Round-robin: under contention the channel that did not win last time is granted.
   always_comb begin
      state_nxt = state;
      grant0    = 1'b0;
      grant1    = 1'b0;
      case (state)
         IDLE: begin
            grant0 = req0_valid & (~req1_valid | last_grant);
            grant1 = req1_valid & (~req0_valid | ~last_grant);
            if (grant0 | grant1) state_nxt = EXEC;
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      alu_y = '0;
      case (opnd.op)
         3'b000:  alu_y = opnd.a + opnd.b;
         3'b001:  alu_y = opnd.a - opnd.b;
         3'b010:  alu_y = opnd.a & opnd.b;
         3'b011:  alu_y = opnd.a | opnd.b;
         3'b100:  alu_y = opnd.a ^ opnd.b;
         3'b101:  alu_y = ~opnd.a;
         3'b110:  alu_y = opnd.a + DW'(1);
         default: alu_y = opnd.a - DW'(1);
      endcase
   end

   // Operand capture on grant, response capture at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opnd       <= '0;
         last_grant <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
         rsp_ch     <= 1'b0;
      end else begin
         if (grant1) begin
            opnd       <= '{a: req1_a, b: req1_b, op: req1_op, ch: 1'b1};
            last_grant <= 1'b1;
         end else if (grant0) begin
            opnd       <= '{a: req0_a, b: req0_b, op: req0_op, ch: 1'b0};
            last_grant <= 1'b0;
         end
         if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_y;
            rsp_zero  <= (alu_y == '0);
            rsp_ch    <= opnd.ch;
         end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Directed bench for alu_arbiter_2ch: vector table plus hand-written arbitration,
// backpressure, reset and withdrawal sequences.
module tb_alu_arbiter_2ch;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req0_ready;
   logic [3:0] req0_a, req0_b;
   logic [2:0] req0_op;
   logic       req1_valid, req1_ready;
   logic [3:0] req1_a, req1_b;
   logic [2:0] req1_op;
   logic       rsp_valid, rsp_ready;
   logic [3:0] rsp_data;
   logic       rsp_zero, rsp_ch;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic       ch;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [3:0] exp_data;
      logic       exp_zero;
   } vec_t;

   vec_t vecs[14];

   alu_arbiter_2ch dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_ch(rsp_ch)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else             n_pass++;
   endtask

   task automatic drive(input logic ch, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op);
      if (ch) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      end
   endtask

   // Full transaction with rsp_ready high; starts and ends on an IDLE negedge.
   task automatic do_txn(input int idx, input vec_t v);
      check($sformatf("v%0d idle_rsp_valid", idx), 32'(rsp_valid), 32'd0);
      drive(v.ch, v.a, v.b, v.op);
      #1;
      check($sformatf("v%0d ready_granted", idx), 32'(v.ch ? req1_ready : req0_ready), 32'd1);
      check($sformatf("v%0d ready_other", idx), 32'(v.ch ? req0_ready : req1_ready), 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d exec_rsp_valid", idx), 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
      check($sformatf("v%0d rsp_zero", idx), 32'(rsp_zero), 32'(v.exp_zero));
      check($sformatf("v%0d rsp_ch", idx), 32'(rsp_ch), 32'(v.ch));
      @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 4'h3, 4'h4, 3'b000, 4'h7, 1'b0};
      vecs[1]  = '{1'b0, 4'h5, 4'h9, 3'b000, 4'hE, 1'b0};
      vecs[2]  = '{1'b0, 4'h5, 4'h9, 3'b001, 4'hC, 1'b0};
      vecs[3]  = '{1'b0, 4'h5, 4'h9, 3'b010, 4'h1, 1'b0};
      vecs[4]  = '{1'b0, 4'h5, 4'h9, 3'b011, 4'hD, 1'b0};
      vecs[5]  = '{1'b0, 4'h5, 4'h9, 3'b100, 4'hC, 1'b0};
      vecs[6]  = '{1'b0, 4'h5, 4'h9, 3'b101, 4'hA, 1'b0};
      vecs[7]  = '{1'b0, 4'h5, 4'h9, 3'b110, 4'h6, 1'b0};
      vecs[8]  = '{1'b0, 4'h5, 4'h9, 3'b111, 4'h4, 1'b0};
      vecs[9]  = '{1'b1, 4'hF, 4'h7, 3'b110, 4'h0, 1'b1};
      vecs[10] = '{1'b1, 4'h0, 4'h3, 3'b111, 4'hF, 1'b0};
      vecs[11] = '{1'b0, 4'h3, 4'h5, 3'b001, 4'hE, 1'b0};
      vecs[12] = '{1'b1, 4'h8, 4'h8, 3'b100, 4'h0, 1'b1};
      vecs[13] = '{1'b1, 4'h6, 4'hF, 3'b101, 4'h9, 1'b0};

      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

      // Reset values
      @(negedge clk); @(negedge clk);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_data", 32'(rsp_data), 32'd0);
      check("rst rsp_zero", 32'(rsp_zero), 32'd0);
      check("rst rsp_ch", 32'(rsp_ch), 32'd0);
      check("rst req0_ready", 32'(req0_ready), 32'd0);
      check("rst req1_ready", 32'(req1_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      check("idle no_req rsp_valid", 32'(rsp_valid), 32'd0);

      for (int i = 0; i < 14; i++) do_txn(i, vecs[i]);

      // Backpressure: response held stable, ready lines low even with a pending request
      rsp_ready = 1'b0;
      drive(1'b1, 4'hF, 4'h0, 3'b110);
      #1 check("bp req1_ready", 32'(req1_ready), 32'd1);
      @(posedge clk); #1 req1_valid = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp%0d rsp_data", i), 32'(rsp_data), 32'd0);
         check($sformatf("bp%0d rsp_zero", i), 32'(rsp_zero), 32'd1);
         check($sformatf("bp%0d rsp_ch", i), 32'(rsp_ch), 32'd1);
         check($sformatf("bp%0d readies", i), 32'({req0_ready, req1_ready}), 32'd0);
         @(negedge clk);
      end
      req0_valid = 1'b0; rsp_ready = 1'b1;
      check("bp release rsp_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      check("bp done rsp_valid", 32'(rsp_valid), 32'd0);

      // Reset during EXEC of a ch0 transaction (last_grant would otherwise be 0)
      drive(1'b0, 4'h2, 4'h2, 3'b000);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rst_mid hold rsp_valid", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid after rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rst_mid no_rsp", 32'(rsp_valid), 32'd0);

      // Contention after reset: ch0 first, then strict alternation
      drive(1'b0, 4'hC, 4'hA, 3'b010);
      drive(1'b1, 4'hC, 4'hA, 3'b100);
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("rr%0d req0_ready", k), 32'(req0_ready), 32'((k % 2) == 0));
         check($sformatf("rr%0d req1_ready", k), 32'(req1_ready), 32'((k % 2) == 1));
         @(negedge clk);
         check($sformatf("rr%0d exec readies", k), 32'({req0_ready, req1_ready}), 32'd0);
         @(negedge clk);
         check($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("rr%0d rsp_data", k), 32'(rsp_data), ((k % 2) == 0) ? 32'h8 : 32'h6);
         check($sformatf("rr%0d rsp_ch", k), 32'(rsp_ch), 32'(k % 2));
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);

      // Withdrawal: ch1 valid only while busy, never served
      rsp_ready = 1'b0;
      drive(1'b0, 4'h1, 4'h1, 3'b000);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      drive(1'b1, 4'h7, 4'h7, 3'b000);
      #1 check("wd req1_ready busy", 32'(req1_ready), 32'd0);
      check("wd ch0 rsp_data", 32'(rsp_data), 32'h2);
      @(negedge clk);
      check("wd req1_ready busy2", 32'(req1_ready), 32'd0);
      req1_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("wd%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
         check($sformatf("wd%0d req1_ready", i), 32'(req1_ready), 32'd0);
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
